// File: rtl/uart_cfg_seq.sv
// ---------------------------------------------------------------------------
// uart_cfg_seq
//   UART line-configuration sequencer. Captures a host configuration request
//   (divisor + line format), holds off new transmit data, waits for the UART
//   to go idle, then applies the divisor and the LCR fields in a fixed order.
//   It waits a settle interval and finishes with a four-phase handshake.
//   The LCR is only ever written after an idle sample, so a reconfiguration
//   cannot raise the busy-write interrupt.
//
// Parameters
//   SETTLE_CYC   cycles spent in SETTLE after the LCR write (1..65535)
//   TIMEOUT_CYC  maximum cycles spent in HOLD before aborting (1..65535)
//   DEF_DIVISOR  reset value of seq_dllh_data
//
// Ports
//   sys_clk, rst_b        clock (rising edge), async active-low reset
//   cfg_req               request level, held until cfg_ack is seen
//   cfg_divisor           requested baud divisor
//   cfg_dls/stop/pen/eps  requested line format
//   uart_busy             combined TX/RX busy
//   uart_thsr_empty       transmit shift register empty
//   cfg_ack, cfg_err      completion level and timeout flag (valid with ack)
//   cfg_busy              sequencer not idle
//   tx_hold               blocks host THR writes
//   seq_dllh_data         current divisor, seq_set_dllh_vld its load strobe
//   seq_lcr_*             current line format, seq_lcr_wen its write strobe
//
// Handshake: cfg_req is a level. Once captured, the request inputs are
// ignored until cfg_ack rises. cfg_ack stays high until cfg_req falls; it
// drops on the edge after that, and a request is only accepted again from
// IDLE.
// ---------------------------------------------------------------------------
module uart_cfg_seq #(
   parameter int unsigned SETTLE_CYC  = 16,
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter logic [15:0] DEF_DIVISOR = 16'h0001
) (
   input  logic        sys_clk,
   input  logic        rst_b,
   input  logic        cfg_req,
   input  logic [15:0] cfg_divisor,
   input  logic [1:0]  cfg_dls,
   input  logic        cfg_stop,
   input  logic        cfg_pen,
   input  logic        cfg_eps,
   input  logic        uart_busy,
   input  logic        uart_thsr_empty,
   output logic        cfg_ack,
   output logic        cfg_err,
   output logic        cfg_busy,
   output logic        tx_hold,
   output logic [15:0] seq_dllh_data,
   output logic        seq_set_dllh_vld,
   output logic [1:0]  seq_lcr_dls,
   output logic        seq_lcr_stop,
   output logic        seq_lcr_pen,
   output logic        seq_lcr_eps,
   output logic        seq_lcr_wen
);

   localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HOLD   = 3'd1,
      ST_DIV    = 3'd2,
      ST_LCR    = 3'd3,
      ST_SETTLE = 3'd4,
      ST_ACK    = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // Shadow copy of the captured request.
   logic [15:0] sh_div;
   logic [1:0]  sh_dls;
   logic        sh_stop;
   logic        sh_pen;
   logic        sh_eps;

   logic [15:0] to_cnt;
   logic [15:0] settle_cnt;

   logic        capture;
   logic        to_inc;
   logic        settle_inc;
   logic        timeout_hit;
   logic        uart_idle;

   assign uart_idle = !uart_busy && uart_thsr_empty;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      capture     = 1'b0;
      to_inc      = 1'b0;
      settle_inc  = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cfg_req) begin
               capture   = 1'b1;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (uart_idle) begin
               // Skip the divisor load when it would not change anything.
               state_nxt = (sh_div != seq_dllh_data) ? ST_DIV : ST_LCR;
            end else if (to_cnt == TIMEOUT_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = ST_ACK;
            end else begin
               to_inc = 1'b1;
            end
         end
         ST_DIV: begin
            state_nxt = ST_LCR;
         end
         ST_LCR: begin
            state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_nxt = ST_ACK;
            end else begin
               settle_inc = 1'b1;
            end
         end
         ST_ACK: begin
            if (!cfg_req) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Shadow registers and counters
   // ------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge rst_b) begin
      if (!rst_b) begin
         sh_div     <= DEF_DIVISOR;
         sh_dls     <= 2'b11;
         sh_stop    <= 1'b0;
         sh_pen     <= 1'b0;
         sh_eps     <= 1'b0;
         to_cnt     <= 16'd0;
         settle_cnt <= 16'd0;
      end else begin
         if (capture) begin
            sh_div  <= cfg_divisor;
            sh_dls  <= cfg_dls;
            sh_stop <= cfg_stop;
            sh_pen  <= cfg_pen;
            sh_eps  <= cfg_eps;
            to_cnt  <= 16'd0;
         end else if (to_inc) begin
            to_cnt <= to_cnt + 16'd1;
         end

         if (state == ST_LCR) begin
            settle_cnt <= 16'd0;
         end else if (settle_inc) begin
            settle_cnt <= settle_cnt + 16'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registered outputs, decoded from the next state so that each output
   // changes on the same edge as the state it belongs to.
   // ------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge rst_b) begin
      if (!rst_b) begin
         seq_dllh_data    <= DEF_DIVISOR;
         seq_set_dllh_vld <= 1'b0;
         seq_lcr_dls      <= 2'b11;
         seq_lcr_stop     <= 1'b0;
         seq_lcr_pen      <= 1'b0;
         seq_lcr_eps      <= 1'b0;
         seq_lcr_wen      <= 1'b0;
         cfg_ack          <= 1'b0;
         cfg_err          <= 1'b0;
         cfg_busy         <= 1'b0;
         tx_hold          <= 1'b0;
      end else begin
         seq_set_dllh_vld <= (state_nxt == ST_DIV);
         seq_lcr_wen      <= (state_nxt == ST_LCR);
         cfg_ack          <= (state_nxt == ST_ACK);
         // Error is set on the timeout edge and held for the whole ACK phase.
         cfg_err          <= timeout_hit || (cfg_err && (state_nxt == ST_ACK));
         cfg_busy         <= (state_nxt != ST_IDLE);
         tx_hold          <= (state_nxt == ST_HOLD) || (state_nxt == ST_DIV) ||
                             (state_nxt == ST_LCR)  || (state_nxt == ST_SETTLE);

         // Data is loaded on the edge entering the strobe cycle so it is
         // already stable while the strobe is high.
         if (state_nxt == ST_DIV) begin
            seq_dllh_data <= sh_div;
         end
         if (state_nxt == ST_LCR) begin
            seq_lcr_dls  <= sh_dls;
            seq_lcr_stop <= sh_stop;
            seq_lcr_pen  <= sh_pen;
            seq_lcr_eps  <= sh_eps;
         end
      end
   end

endmodule

// File: tb/tb_uart_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_uart_cfg_seq
//   Two sequencer instances share one set of inputs: dut_a with a long
//   timeout (busy waits complete) and dut_b with an 8-cycle timeout (busy
//   waits abort). Expected per-cycle output vectors are computed from the
//   request-level rules (first idle sample, divisor change, settle length)
//   and queued before each request is driven.
// ---------------------------------------------------------------------------
module tb_uart_cfg_seq;

   localparam int S  = 4;
   localparam int TA = 32;
   localparam int TB = 8;
   localparam int W  = 27;

   localparam logic [15:0] RST_DIV = 16'h0001;
   localparam logic [4:0]  RST_LCR = 5'b11000;

   // ------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------
   logic sys_clk = 1'b0;
   logic rst_b   = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic        cfg_req = 1'b0;
   logic [15:0] cfg_divisor = 16'h0;
   logic [1:0]  cfg_dls = 2'b0;
   logic        cfg_stop = 1'b0;
   logic        cfg_pen = 1'b0;
   logic        cfg_eps = 1'b0;
   logic        uart_busy = 1'b0;
   logic        uart_thsr_empty = 1'b1;

   logic        a_ack, a_err, a_busy, a_hold, a_vld, a_wen, a_stop, a_pen, a_eps;
   logic [15:0] a_div;
   logic [1:0]  a_dls;
   logic        b_ack, b_err, b_busy, b_hold, b_vld, b_wen, b_stop, b_pen, b_eps;
   logic [15:0] b_div;
   logic [1:0]  b_dls;

   uart_cfg_seq #(.SETTLE_CYC(S), .TIMEOUT_CYC(TA), .DEF_DIVISOR(RST_DIV)) dut_a (
      .sys_clk(sys_clk), .rst_b(rst_b), .cfg_req(cfg_req), .cfg_divisor(cfg_divisor),
      .cfg_dls(cfg_dls), .cfg_stop(cfg_stop), .cfg_pen(cfg_pen), .cfg_eps(cfg_eps),
      .uart_busy(uart_busy), .uart_thsr_empty(uart_thsr_empty),
      .cfg_ack(a_ack), .cfg_err(a_err), .cfg_busy(a_busy), .tx_hold(a_hold),
      .seq_dllh_data(a_div), .seq_set_dllh_vld(a_vld), .seq_lcr_dls(a_dls),
      .seq_lcr_stop(a_stop), .seq_lcr_pen(a_pen), .seq_lcr_eps(a_eps), .seq_lcr_wen(a_wen)
   );

   uart_cfg_seq #(.SETTLE_CYC(S), .TIMEOUT_CYC(TB), .DEF_DIVISOR(RST_DIV)) dut_b (
      .sys_clk(sys_clk), .rst_b(rst_b), .cfg_req(cfg_req), .cfg_divisor(cfg_divisor),
      .cfg_dls(cfg_dls), .cfg_stop(cfg_stop), .cfg_pen(cfg_pen), .cfg_eps(cfg_eps),
      .uart_busy(uart_busy), .uart_thsr_empty(uart_thsr_empty),
      .cfg_ack(b_ack), .cfg_err(b_err), .cfg_busy(b_busy), .tx_hold(b_hold),
      .seq_dllh_data(b_div), .seq_set_dllh_vld(b_vld), .seq_lcr_dls(b_dls),
      .seq_lcr_stop(b_stop), .seq_lcr_pen(b_pen), .seq_lcr_eps(b_eps), .seq_lcr_wen(b_wen)
   );

   // Observed vector: {ack, err, busy, hold, dllh_vld, lcr_wen, div[15:0], dls, stop, pen, eps}
   logic [W-1:0] obs_a, obs_b;
   assign obs_a = {a_ack, a_err, a_busy, a_hold, a_vld, a_wen, a_div, a_dls, a_stop, a_pen, a_eps};
   assign obs_b = {b_ack, b_err, b_busy, b_hold, b_vld, b_wen, b_div, b_dls, b_stop, b_pen, b_eps};

   // ------------------------------------------------------------------
   // Scoreboard state
   // ------------------------------------------------------------------
   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_qa[$];
   logic [W-1:0] exp_qb[$];

   // Reference configuration held by each instance.
   logic [15:0] m_div[2];
   logic [4:0]  m_lcr[2];

   // Per-evaluation input pattern for the HOLD phase (index = edge number).
   bit pat_busy[64];
   bit pat_thsr[64];
   bit pat_idle[64];

   // Per-request observations.
   int res_ack[2];
   int res_vld[2];
   int res_err[2];

   typedef struct {
      logic [15:0] div;
      logic [4:0]  lcr;
      int          busy_n;
      int          hold_n;
      int          ack_a;
      int          ack_b;
      int          vld_a;
      int          err_b;
   } vec_t;
   vec_t tab[6];

   function automatic logic [W-1:0] pack(input logic ack, input logic err, input logic busy,
                                         input logic hold, input logic vld, input logic wen,
                                         input logic [15:0] div, input logic [4:0] lcr);
      return {ack, err, busy, hold, vld, wen, div, lcr};
   endfunction

   task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Request-level model: where the first idle sample lands decides everything.
   task automatic plan(input int d, input int t, input logic [15:0] div,
                       output int ack_k, output int dv, output int lw, output bit to);
      int e;
      e = 0;
      for (int j = 1; j <= t; j++) begin
         if (e == 0 && pat_idle[j]) e = j;
      end
      to = (e == 0);
      if (to) begin
         dv = -1; lw = -1; ack_k = t;
      end else if (div != m_div[d]) begin
         dv = e; lw = e + 1; ack_k = e + 2 + S;
      end else begin
         dv = -1; lw = e; ack_k = e + 1 + S;
      end
   endtask

   function automatic logic [W-1:0] exp_at(input int k, input int ack_k, input int dv,
                                           input int lw, input bit to,
                                           input logic [15:0] old_div, input logic [15:0] new_div,
                                           input logic [4:0] old_lcr, input logic [4:0] new_lcr);
      logic a;
      a = (k >= ack_k);
      return pack(a, a && to, 1'b1, !a, k == dv, k == lw,
                  (dv >= 0 && k >= dv) ? new_div : old_div,
                  (lw >= 0 && k >= lw) ? new_lcr : old_lcr);
   endfunction

   task automatic pop_check(input int k);
      logic [W-1:0] e;
      if (exp_qa.size() == 0 || exp_qb.size() == 0) begin
         total++; bad++;
         $display("FAIL queue_empty cyc=%0d got=%0d/%0d exp=nonzero", k, exp_qa.size(), exp_qb.size());
      end else begin
         e = exp_qa.pop_front();
         check_vec($sformatf("a_cyc%0d", k), obs_a, e);
         e = exp_qb.pop_front();
         check_vec($sformatf("b_cyc%0d", k), obs_b, e);
      end
   endtask

   // ------------------------------------------------------------------
   // Driver: one full request, from capture to the return to IDLE.
   // busy_n >= 0: uart_busy high for the first busy_n HOLD samples.
   // busy_n <  0: random busy / thsr pattern.
   // ------------------------------------------------------------------
   task automatic run_req(input logic [15:0] div, input logic [4:0] lcr,
                          input int busy_n, input int hold_n);
      int ack_k[2];
      int dv[2];
      int lw[2];
      bit to[2];
      int last;
      int thr;
      logic [W-1:0] v;
      thr = 0;
      case ($urandom_range(0, 3))
         0:       thr = 0;
         1:       thr = 50;
         2:       thr = 85;
         default: thr = 100;
      endcase
      for (int j = 0; j < 64; j++) begin
         if (busy_n >= 0) begin
            pat_busy[j] = (j >= 1 && j <= busy_n);
            pat_thsr[j] = 1'b1;
         end else begin
            pat_busy[j] = ($urandom_range(0, 99) < thr);
            pat_thsr[j] = ($urandom_range(0, 9) != 0);
         end
         pat_idle[j] = !pat_busy[j] && pat_thsr[j];
      end

      plan(0, TA, div, ack_k[0], dv[0], lw[0], to[0]);
      plan(1, TB, div, ack_k[1], dv[1], lw[1], to[1]);
      last = ((ack_k[0] > ack_k[1]) ? ack_k[0] : ack_k[1]) + hold_n;

      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k <= last; k++) begin
            v = exp_at(k, ack_k[d], dv[d], lw[d], to[d], m_div[d], div, m_lcr[d], lcr);
            if (d == 0) exp_qa.push_back(v); else exp_qb.push_back(v);
         end
         if (!to[d]) begin
            if (dv[d] >= 0) m_div[d] = div;
            m_lcr[d] = lcr;
         end
         v = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_div[d], m_lcr[d]);
         if (d == 0) exp_qa.push_back(v); else exp_qb.push_back(v);
         res_ack[d] = -1;
         res_vld[d] = 0;
         res_err[d] = 0;
      end

      cfg_req     = 1'b1;
      cfg_divisor = div;
      {cfg_dls, cfg_stop, cfg_pen, cfg_eps} = lcr;
      uart_busy       = pat_busy[0];
      uart_thsr_empty = pat_thsr[0];
      for (int k = 0; k <= last; k++) begin
         if (k > 0) begin
            // Request fields are free to change once captured.
            cfg_divisor = 16'($urandom);
            {cfg_dls, cfg_stop, cfg_pen, cfg_eps} = 5'($urandom);
            uart_busy       = pat_busy[k];
            uart_thsr_empty = pat_thsr[k];
         end
         @(posedge sys_clk);
         #1;
         pop_check(k);
         if (a_ack && res_ack[0] < 0) res_ack[0] = k;
         if (b_ack && res_ack[1] < 0) res_ack[1] = k;
         if (a_vld) res_vld[0]++;
         if (b_vld) res_vld[1]++;
         if (a_err) res_err[0] = 1;
         if (b_err) res_err[1] = 1;
      end
      cfg_req = 1'b0;
      @(posedge sys_clk);
      #1;
      pop_check(last + 1);
   endtask

   // ------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------
   initial begin
      int ack_seen;
      logic [15:0] rdiv;

      //            div       lcr       busy hold ack_a ack_b vld_a err_b
      tab[0] = '{16'h001A, 5'b10011,  0,   0,   7,    7,    1,    0}; // basic reconfiguration
      tab[1] = '{16'h001A, 5'b01100,  0,   2,   6,    6,    0,    0}; // same divisor, LCR only
      tab[2] = '{16'h0100, 5'b11111, 20,   0,  27,    8,    1,    1}; // busy 20: a waits, b times out
      tab[3] = '{16'h0200, 5'b00001, 40,   0,  32,    8,    0,    1}; // both time out
      tab[4] = '{16'h0003, 5'b00010,  3,  10,  10,   10,    1,    0}; // ack held 10 cycles
      tab[5] = '{16'h0003, 5'b11000,  7,   0,  13,   13,    0,    0}; // idle on b's last HOLD sample

      for (int d = 0; d < 2; d++) begin
         m_div[d] = RST_DIV;
         m_lcr[d] = RST_LCR;
      end

      // Reset state
      rst_b = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      check_vec("reset_a", obs_a, pack(0, 0, 0, 0, 0, 0, RST_DIV, RST_LCR));
      check_vec("reset_b", obs_b, pack(0, 0, 0, 0, 0, 0, RST_DIV, RST_LCR));
      rst_b = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;

      // Directed table
      for (int i = 0; i < 6; i++) begin
         run_req(tab[i].div, tab[i].lcr, tab[i].busy_n, tab[i].hold_n);
         check_int($sformatf("tab%0d_ack_a", i), res_ack[0], tab[i].ack_a);
         check_int($sformatf("tab%0d_ack_b", i), res_ack[1], tab[i].ack_b);
         check_int($sformatf("tab%0d_vld_a", i), res_vld[0], tab[i].vld_a);
         check_int($sformatf("tab%0d_err_b", i), res_err[1], tab[i].err_b);
      end

      // Reset in the middle of SETTLE
      cfg_req = 1'b1;
      cfg_divisor = 16'h0055;
      {cfg_dls, cfg_stop, cfg_pen, cfg_eps} = 5'b01011;
      uart_busy = 1'b0;
      uart_thsr_empty = 1'b1;
      repeat (5) @(posedge sys_clk);
      #1;
      check_vec("pre_reset_settle_a", obs_a, pack(0, 0, 1, 1, 0, 0, 16'h0055, 5'b01011));
      #2;
      rst_b = 1'b0;
      #1;
      check_vec("mid_reset_a", obs_a, pack(0, 0, 0, 0, 0, 0, RST_DIV, RST_LCR));
      check_vec("mid_reset_b", obs_b, pack(0, 0, 0, 0, 0, 0, RST_DIV, RST_LCR));
      cfg_req = 1'b0;
      #1;
      rst_b = 1'b1;
      for (int d = 0; d < 2; d++) begin
         m_div[d] = RST_DIV;
         m_lcr[d] = RST_LCR;
      end
      ack_seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge sys_clk);
         #1;
         if (a_ack || b_ack || a_busy || b_busy) ack_seen++;
      end
      check_int("post_reset_no_ack", ack_seen, 0);
      check_vec("post_reset_a", obs_a, pack(0, 0, 0, 0, 0, 0, RST_DIV, RST_LCR));

      // Randomized requests
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) rdiv = m_div[0];
         else rdiv = 16'($urandom);
         run_req(rdiv, 5'($urandom), -1, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
